// File: rtl/stoch_pkg.sv
// Shared types and constants for the stochastic add/multiply sequencer.
package stoch_pkg;

  typedef enum logic [1:0] {
    OP_MUL    = 2'b00,
    OP_SADD   = 2'b01,
    OP_PASS_A = 2'b10,
    OP_PASS_B = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_SEED = 2'b01,
    S_RUN  = 2'b10,
    S_DONE = 2'b11
  } state_t;

  localparam int unsigned STREAM_LEN     = 255;
  localparam logic [7:0]  DEFAULT_TAPS   = 8'hB8;
  localparam logic [7:0]  DEFAULT_SEED_A = 8'h01;
  localparam logic [7:0]  DEFAULT_SEED_B = 8'hA5;

endpackage

// File: rtl/stoch_lfsr.sv
// Fibonacci LFSR stochastic number source with seed reload; load has priority over step.
module stoch_lfsr
  import stoch_pkg::*;
#(
  parameter int unsigned      WIDTH = 8,
  parameter logic [WIDTH-1:0] TAPS  = DEFAULT_TAPS,
  parameter logic [WIDTH-1:0] SEED  = DEFAULT_SEED_A
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  output logic [WIDTH-1:0] value
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value <= SEED;
    end else if (load) begin
      value <= SEED;
    end else if (step) begin
      value <= {value[WIDTH-2:0], ^(value & TAPS)};
    end
  end

endmodule

// File: rtl/stoch_seq_ctrl.sv
// Sequencer: latches operands, drives two LFSR SNGs, combines streams and counts ones
// over one full LFSR period.
module stoch_seq_ctrl
  import stoch_pkg::*;
#(
  parameter int unsigned      WIDTH  = 8,
  parameter logic [WIDTH-1:0] TAPS   = DEFAULT_TAPS,
  parameter logic [WIDTH-1:0] SEED_A = DEFAULT_SEED_A,
  parameter logic [WIDTH-1:0] SEED_B = DEFAULT_SEED_B
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             sa_bit,
  output logic             sb_bit,
  output logic             so_bit
);

  // Step counter saturates here: one extra RUN cycle commits the count.
  localparam logic [WIDTH-1:0] LAST_STEP = '1;

  state_t           state_q, state_d;
  op_t              op_q;
  logic [WIDTH-1:0] op_a_q, op_b_q;
  logic [WIDTH-1:0] ones_q, step_q;
  logic             sel_q;
  logic             lfsr_load, run_step;
  logic [WIDTH-1:0] lfsr_a, lfsr_b;
  logic             a_raw, b_raw, o_raw;

  stoch_lfsr #(
    .WIDTH (WIDTH),
    .TAPS  (TAPS),
    .SEED  (SEED_A)
  ) u_lfsr_a (
    .clk   (clk),
    .rst   (rst),
    .load  (lfsr_load),
    .step  (run_step),
    .value (lfsr_a)
  );

  stoch_lfsr #(
    .WIDTH (WIDTH),
    .TAPS  (TAPS),
    .SEED  (SEED_B)
  ) u_lfsr_b (
    .clk   (clk),
    .rst   (rst),
    .load  (lfsr_load),
    .step  (run_step),
    .value (lfsr_b)
  );

  always_comb begin
    a_raw = (lfsr_a <= op_a_q);
    b_raw = (lfsr_b <= op_b_q);
    o_raw = 1'b0;
    unique case (op_q)
      OP_MUL:    o_raw = a_raw & b_raw;
      OP_SADD:   o_raw = sel_q ? b_raw : a_raw;
      OP_PASS_A: o_raw = a_raw;
      OP_PASS_B: o_raw = b_raw;
      default:   o_raw = 1'b0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    lfsr_load = 1'b0;
    run_step  = 1'b0;
    busy      = (state_q != S_IDLE);
    done      = (state_q == S_DONE);
    unique case (state_q)
      S_IDLE: if (start) state_d = S_SEED;
      S_SEED: begin
        lfsr_load = 1'b1;
        state_d   = abort ? S_IDLE : S_RUN;
      end
      S_RUN: begin
        run_step = (step_q != LAST_STEP);
        if (abort) state_d = S_IDLE;
        else if (step_q == LAST_STEP) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign sa_bit = run_step & a_raw;
  assign sb_bit = run_step & b_raw;
  assign so_bit = run_step & o_raw;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_q    <= OP_MUL;
      op_a_q  <= '0;
      op_b_q  <= '0;
      ones_q  <= '0;
      step_q  <= '0;
      sel_q   <= 1'b0;
      result  <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE && start) begin
        op_q   <= op_t'(op);
        op_a_q <= op_a;
        op_b_q <= op_b;
      end
      if (lfsr_load) begin
        ones_q <= '0;
        step_q <= '0;
        sel_q  <= 1'b0;
      end else if (run_step) begin
        ones_q <= ones_q + WIDTH'(o_raw);
        step_q <= step_q + WIDTH'(1);
        sel_q  <= ~sel_q;
      end
      if (state_q == S_RUN && !abort && step_q == LAST_STEP) result <= ones_q;
    end
  end

endmodule

// File: tb/tb_stoch_seq_ctrl.sv
// Directed bench for stoch_seq_ctrl: exact pass-through, MUL/SADD ranges, abort, reset, timing.
module tb_stoch_seq_ctrl;
  import stoch_pkg::*;

  logic       clk, rst, start, abort;
  logic [1:0] op;
  logic [7:0] op_a, op_b;
  logic       busy, done;
  logic [7:0] result;
  logic       sa_bit, sb_bit, so_bit;

  int checks = 0;
  int errors = 0;

  stoch_seq_ctrl #(
    .WIDTH  (8),
    .TAPS   (8'hB8),
    .SEED_A (8'h01),
    .SEED_B (8'hA5)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .abort  (abort),
    .op     (op),
    .op_a   (op_a),
    .op_b   (op_b),
    .busy   (busy),
    .done   (done),
    .result (result),
    .sa_bit (sa_bit),
    .sb_bit (sb_bit),
    .so_bit (so_bit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_range(input string tag, input logic [31:0] obs, input int lo, input int hi);
    checks++;
    assert (!$isunknown(obs) && int'(obs) >= lo && int'(obs) <= hi) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
    end
  endtask

  // Start one run (inputs change 1ns after an edge) and follow it until busy drops.
  task automatic run_op(input op_t o, input logic [7:0] a, input logic [7:0] b,
                        output logic [7:0] res, output int done_at, output int busy_cnt,
                        output int done_cnt);
    op = o; op_a = a; op_b = b; start = 1'b1;
    tick();
    start = 1'b0;
    done_at = -1; busy_cnt = 0; done_cnt = 0;
    for (int n = 0; n < 400 && busy; n++) begin
      if (done) begin
        done_cnt++;
        if (done_at < 0) done_at = n;
      end
      busy_cnt++;
      tick();
    end
    res = result;
  endtask

  task automatic full_run(input string tag, input op_t o, input logic [7:0] a,
                          input logic [7:0] b, input logic [7:0] exp);
    logic [7:0] res;
    int done_at, busy_cnt, done_cnt;
    run_op(o, a, b, res, done_at, busy_cnt, done_cnt);
    check({tag, "_result"}, res, exp);
    check({tag, "_done_cnt"}, done_cnt, 1);
    check({tag, "_idle"}, busy, 1'b0);
  endtask

  initial begin
    logic [7:0] res, res2;
    int done_at, busy_cnt, done_cnt, d0, d1, idle_cnt;

    rst = 1'b1; start = 1'b0; abort = 1'b0; op = 2'b00; op_a = '0; op_b = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_result", result, 8'd0);
    check("rst_streams", {sa_bit, sb_bit, so_bit}, 3'b000);
    rst = 1'b0;
    tick();

    // Timing and exact pass-through
    run_op(OP_PASS_A, 8'd200, 8'd0, res, done_at, busy_cnt, done_cnt);
    check("pa200_result", res, 8'd200);
    check("pa200_done_edge", done_at, 257);
    check("pa200_busy_cycles", busy_cnt, 258);
    check("pa200_done_cnt", done_cnt, 1);
    run_op(OP_PASS_B, 8'd50, 8'd13, res, done_at, busy_cnt, done_cnt);
    check("pb13_result", res, 8'd13);
    check("pb13_done_edge", done_at, 257);
    check("pb13_busy_cycles", busy_cnt, 258);

    // Asynchronous reset in the middle of RUN
    op = OP_PASS_A; op_a = 8'd5; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (50) tick();
    check("midrun_busy", busy, 1'b1);
    rst = 1'b1;
    #1;
    check("midrst_busy", busy, 1'b0);
    check("midrst_done", done, 1'b0);
    check("midrst_result", result, 8'd0);
    check("midrst_so", so_bit, 1'b0);
    tick();
    rst = 1'b0;
    tick();
    full_run("pa77", OP_PASS_A, 8'd77, 8'd0, 8'd77);

    full_run("mul_255_128", OP_MUL, 8'd255, 8'd128, 8'd128);
    full_run("mul_0_255", OP_MUL, 8'd0, 8'd255, 8'd0);
    run_op(OP_MUL, 8'd128, 8'd128, res, done_at, busy_cnt, done_cnt);
    check_range("mul_128_128", res, 52, 76);
    run_op(OP_MUL, 8'd128, 8'd128, res2, done_at, busy_cnt, done_cnt);
    check("mul_128_repeat", res2, res);

    full_run("sadd_255_255", OP_SADD, 8'd255, 8'd255, 8'd255);
    full_run("sadd_0_0", OP_SADD, 8'd0, 8'd0, 8'd0);
    run_op(OP_SADD, 8'd255, 8'd0, res, done_at, busy_cnt, done_cnt);
    check_range("sadd_255_0", res, 119, 135);

    // Abort at RUN step 100 keeps the previous result
    full_run("pre_abort", OP_PASS_A, 8'd200, 8'd0, 8'd200);
    op = OP_PASS_B; op_b = 8'd13; start = 1'b1;
    tick();
    start = 1'b0;
    done_cnt = 0;
    for (int n = 0; n < 101; n++) begin
      if (done) done_cnt++;
      tick();
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_busy", busy, 1'b0);
    check("abort_done", done, 1'b0);
    check("abort_no_done", done_cnt, 0);
    check("abort_result", result, 8'd200);
    full_run("post_abort", OP_PASS_B, 8'd0, 8'd13, 8'd13);

    // start while busy is ignored
    op = OP_PASS_A; op_a = 8'd200; op_b = 8'd0; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (10) tick();
    op = OP_PASS_B; op_a = 8'd50; op_b = 8'd13; start = 1'b1;
    tick();
    start = 1'b0;
    done_cnt = 0;
    for (int n = 0; n < 400 && busy; n++) begin
      if (done) done_cnt++;
      tick();
    end
    check("ignore_result", result, 8'd200);
    check("ignore_done_cnt", done_cnt, 1);
    tick();
    check("ignore_no_queue", busy, 1'b0);

    // start held high: back-to-back runs
    op = OP_PASS_A; op_a = 8'd99; start = 1'b1;
    tick();
    d0 = -1; d1 = -1; idle_cnt = 0;
    for (int n = 0; n < 800 && d1 < 0; n++) begin
      if (done) begin
        if (d0 < 0) d0 = n;
        else d1 = n;
      end
      if (d0 >= 0 && d1 < 0 && !busy) idle_cnt++;
      if (d1 < 0) tick();
    end
    start = 1'b0;
    check("b2b_first_done", d0, 257);
    check("b2b_gap", d1 - d0, 259);
    check("b2b_idle_cycles", idle_cnt, 1);
    check("b2b_result", result, 8'd99);
    for (int n = 0; n < 10 && busy; n++) tick();
    check("b2b_end_idle", busy, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
